decoder_2x4_pulse: RTL and testbench



---
 rtl/enc_dec_pkg.sv | 18 +
 rtl/decoder_2x4_pulse_pulse_timer.sv | 24 ++
 rtl/decoder_2x4_pulse.sv | 120 ++++++++++++
 tb/tb_decoder_2x4_pulse.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/enc_dec_pkg.sv
// Shared types and helpers for the encoded-index pulse decoder.
// The one-hot helper is sized for the widest supported index (8 bits).
package enc_dec_pkg;

   localparam int N_DEF     = 2;
   localparam int MAX_LINES = 256;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } state_t;

   function automatic logic [MAX_LINES-1:0] onehot(input logic [7:0] code);
      return {{(MAX_LINES-1){1'b0}}, 1'b1} << code;
   endfunction

endpackage

// File: rtl/decoder_2x4_pulse_pulse_timer.sv
// Loadable 8-bit down-counter with zero flag; times both the pulse and the gap.
module pulse_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_load,
   input  logic [7:0] i_load_val,
   input  logic       i_dec,
   output logic       o_zero
);

   logic [7:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= 8'd0;
      else if (i_load)
         r_cnt <= i_load_val;
      else if (i_dec && (r_cnt != 8'd0))
         r_cnt <= r_cnt - 8'd1;
   end

   assign o_zero = (r_cnt == 8'd0);

endmodule

// File: rtl/decoder_2x4_pulse.sv
// Turns an accepted encoded index into a fixed-length one-hot pulse, with
// an optional idle gap, a sticky hit vector and a saturating accept count.
module decoder_2x4_pulse
   import enc_dec_pkg::*;
#(
   parameter int N         = N_DEF,
   parameter int PULSE_LEN = 3,
   parameter int GAP_LEN   = 1,
   parameter int CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [N-1:0]      in_code,
   output logic              in_ready,
   output logic [2**N-1:0]   dout,
   output logic              busy,
   output logic [2**N-1:0]   hit,
   input  logic              hit_clr,
   output logic [CNT_W-1:0]  acc_cnt
);

   localparam int         LINES    = 2**N;
   localparam logic [7:0] PULSE_LD = 8'(PULSE_LEN - 1);
   localparam logic [7:0] GAP_LD   = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'd0;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [N-1:0]       r_code;
   logic [LINES-1:0]   r_dout;
   logic [LINES-1:0]   r_hit;
   logic [LINES-1:0]   w_oh_in;
   logic               r_busy;
   logic [CNT_W-1:0]   r_acc;
   logic               w_accept;
   logic               w_load;
   logic [7:0]         w_load_val;
   logic               w_zero;

   assign w_accept = in_valid && (r_state == IDLE);
   assign w_oh_in  = LINES'(onehot(8'(in_code)));

   pulse_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_dec      (r_state != IDLE),
      .o_zero     (w_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_load_val  = PULSE_LD;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_state_nxt = PULSE;
               w_load      = 1'b1;
               w_load_val  = PULSE_LD;
            end
         end
         PULSE: begin
            if (w_zero) begin
               if (GAP_LEN > 0) begin
                  w_state_nxt = GAP;
                  w_load      = 1'b1;
                  w_load_val  = GAP_LD;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         GAP: begin
            if (w_zero)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // in_code is only looked at on an accept, so X on an idle bus never reaches a register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_code <= '0;
         r_dout <= '0;
         r_busy <= 1'b0;
         r_hit  <= '0;
         r_acc  <= '0;
      end else begin
         r_busy <= (w_state_nxt != IDLE);
         if (w_accept) begin
            r_code <= in_code;
            r_dout <= w_oh_in;
            r_hit  <= (hit_clr ? '0 : r_hit) | w_oh_in;
            if (r_acc != {CNT_W{1'b1}})
               r_acc <= r_acc + 1'b1;
         end else begin
            r_dout <= (w_state_nxt == PULSE) ? r_dout : '0;
            if (hit_clr)
               r_hit <= '0;
         end
      end
   end

   assign in_ready = (r_state == IDLE);
   assign dout     = r_dout;
   assign busy     = r_busy;
   assign hit      = r_hit;
   assign acc_cnt  = r_acc;

endmodule

// File: tb/tb_decoder_2x4_pulse.sv
// Three decoder instances (default, PULSE_LEN=1/GAP_LEN=0, CNT_W=2) checked
// every cycle against a timestamp-based reference model.
module tb_decoder_2x4_pulse;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid [3];
   logic [1:0] in_code  [3];
   logic       hit_clr  [3];
   logic       in_ready [3];
   logic       busy     [3];
   logic [3:0] dout     [3];
   logic [3:0] hit      [3];
   logic [7:0] acc0, acc1;
   logic [1:0] acc2;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc;
   int         m_last [3];
   int         m_code [3];
   logic [3:0] m_hit  [3];
   int         m_acc  [3];

   always #5 clk = ~clk;

   decoder_2x4_pulse u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_code(in_code[0]),
      .in_ready(in_ready[0]), .dout(dout[0]), .busy(busy[0]), .hit(hit[0]),
      .hit_clr(hit_clr[0]), .acc_cnt(acc0));

   decoder_2x4_pulse #(.PULSE_LEN(1), .GAP_LEN(0)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_code(in_code[1]),
      .in_ready(in_ready[1]), .dout(dout[1]), .busy(busy[1]), .hit(hit[1]),
      .hit_clr(hit_clr[1]), .acc_cnt(acc1));

   decoder_2x4_pulse #(.CNT_W(2)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_code(in_code[2]),
      .in_ready(in_ready[2]), .dout(dout[2]), .busy(busy[2]), .hit(hit[2]),
      .hit_clr(hit_clr[2]), .acc_cnt(acc2));

   function automatic int pl(int i);
      return (i == 1) ? 1 : 3;
   endfunction

   function automatic int gl(int i);
      return (i == 1) ? 0 : 1;
   endfunction

   function automatic int cmax(int i);
      return (i == 2) ? 3 : 255;
   endfunction

   function automatic logic [7:0] acc_of(int i);
      case (i)
         0:       return acc0;
         1:       return acc1;
         default: return {6'd0, acc2};
      endcase
   endfunction

   // busy for PULSE_LEN+GAP_LEN cycles after each accept edge
   function automatic bit m_busy(int i);
      int e;
      e = cyc - m_last[i];
      return (e >= 1) && (e <= pl(i) + gl(i));
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      cyc = 0;
      for (int i = 0; i < 3; i++) begin
         m_last[i] = -1000;
         m_code[i] = 0;
         m_hit[i]  = 4'b0;
         m_acc[i]  = 0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 3; i++) begin
         if (in_valid[i] && !m_busy(i)) begin
            m_last[i] = cyc;
            m_code[i] = int'(in_code[i]);
            m_hit[i]  = (hit_clr[i] ? 4'b0 : m_hit[i]) | (4'b1 << in_code[i]);
            if (m_acc[i] < cmax(i)) m_acc[i]++;
         end else if (hit_clr[i]) begin
            m_hit[i] = 4'b0;
         end
      end
      cyc++;
   endtask

   task automatic check_all();
      int e;
      logic [3:0] exp_dout;
      bit exp_busy;
      for (int i = 0; i < 3; i++) begin
         e = cyc - m_last[i];
         exp_dout = ((e >= 1) && (e <= pl(i))) ? (4'b1 << m_code[i]) : 4'b0;
         exp_busy = m_busy(i);
         check_val($sformatf("u%0d dout c%0d", i, cyc), 32'(dout[i]), 32'(exp_dout));
         check_val($sformatf("u%0d busy c%0d", i, cyc), 32'(busy[i]), 32'(exp_busy));
         check_val($sformatf("u%0d in_ready c%0d", i, cyc), 32'(in_ready[i]), 32'(!exp_busy));
         check_val($sformatf("u%0d hit c%0d", i, cyc), 32'(hit[i]), 32'(m_hit[i]));
         check_val($sformatf("u%0d acc_cnt c%0d", i, cyc), 32'(acc_of(i)), 32'(m_acc[i]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle_all();
      for (int i = 0; i < 3; i++) begin
         in_valid[i] = 1'b0;
         in_code[i]  = 2'bxx;
         hit_clr[i]  = 1'b0;
      end
   endtask

   task automatic wait_ready(input int i);
      for (int k = 0; k < 20 && m_busy(i); k++) tick();
      check_val($sformatf("u%0d wait_ready", i), 32'(in_ready[i]), 32'd1);
   endtask

   task automatic accept_one(input int i, input logic [1:0] code, input logic clr);
      wait_ready(i);
      in_valid[i] = 1'b1;
      in_code[i]  = code;
      hit_clr[i]  = clr;
      tick();
      in_valid[i] = 1'b0;
      in_code[i]  = 2'bxx;
      hit_clr[i]  = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_all();
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      check_all();
      repeat (10) tick();

      // single accept of code 2
      accept_one(0, 2'd2, 1'b0);
      repeat (6) tick();
      check_val("single hit", 32'(hit[0]), 32'h4);
      check_val("single acc", 32'(acc0), 32'd1);

      // valid held high while the code steps every cycle
      in_valid[0] = 1'b1;
      for (int k = 0; k < 16; k++) begin
         case (k % 3)
            0:       in_code[0] = 2'd3;
            1:       in_code[0] = 2'd1;
            default: in_code[0] = 2'd0;
         endcase
         tick();
         check_val("onehot u0", 32'($countones(dout[0]) <= 1), 32'd1);
      end
      idle_all();

      // shortest pulse, no gap, continuous requests
      in_valid[1] = 1'b1;
      in_code[1]  = 2'd1;
      repeat (10) tick();
      idle_all();

      // hit_clr coinciding with an accept
      hit_clr[0] = 1'b1;
      tick();
      hit_clr[0] = 1'b0;
      accept_one(0, 2'd1, 1'b0);
      accept_one(0, 2'd3, 1'b0);
      wait_ready(0);
      check_val("hit before clr", 32'(hit[0]), 32'hA);
      accept_one(0, 2'd0, 1'b1);
      check_val("hit clr+set", 32'(hit[0]), 32'h1);

      // counter saturation on the 2-bit instance
      for (int k = 0; k < 5; k++) accept_one(2, 2'(k), 1'b0);
      wait_ready(2);
      check_val("acc saturate", 32'(acc2), 32'd3);

      // randomized traffic on all instances
      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < 3; i++) begin
            in_valid[i] = ($urandom_range(0, 9) < 6);
            in_code[i]  = 2'($urandom_range(0, 3));
            hit_clr[i]  = ($urandom_range(0, 9) == 0);
         end
         tick();
      end
      idle_all();

      // asynchronous reset during the second pulse cycle
      wait_ready(0);
      in_valid[0] = 1'b1;
      in_code[0]  = 2'd3;
      tick();
      idle_all();
      tick();
      check_val("pre_rst dout", 32'(dout[0]), 32'h8);
      #2 rst = 1'b1;
      #1;
      check_val("async_rst dout", 32'(dout[0]), 32'h0);
      check_val("async_rst busy", 32'(busy[0]), 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check_all();
      repeat (5) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
